// File: rtl/pu_msp430_glbl_pkg.sv
// Shared types and helpers for the global reset/tristate/preload controller.
`timescale 1ns/1ps
package pu_msp430_glbl_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SEQ  = 2'd1,
        DONE = 2'd2
    } glbl_state_e;

    localparam int NREQ_MAX = 8;

    function automatic int cnt_width(input int roc_cycles);
        return $clog2(roc_cycles + 1);
    endfunction

endpackage

// File: rtl/pu_msp430_glbl_rr_arb.sv
// Combinational round-robin arbiter: first set request above the pointer, wrapping.
// Zero latency; no backpressure, the parent samples the result only in IDLE.
`timescale 1ns/1ps
module pu_msp430_glbl_rr_arb #(
    parameter int NREQ = 3,
    parameter int PW   = 2
) (
    input  logic [NREQ-1:0] req_i,
    input  logic [PW-1:0]   ptr_i,
    output logic [NREQ-1:0] gnt_o,
    output logic [PW-1:0]   idx_o,
    output logic            any_o
);

    function automatic logic [PW-1:0] wrap(input int v);
        return PW'(v % NREQ);
    endfunction

    // Offset 1..NREQ from the last winner, so the last winner is searched last.
    always_comb begin
        gnt_o = '0;
        idx_o = '0;
        any_o = 1'b0;
        for (int i = 1; i <= NREQ; i++) begin
            if (!any_o && req_i[wrap(int'(ptr_i) + i)]) begin
                any_o                       = 1'b1;
                idx_o                       = wrap(int'(ptr_i) + i);
                gnt_o[wrap(int'(ptr_i) + i)] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/pu_msp430_glbl_ctrl.sv
// Power-on and on-request GSR/GTS/PRLD sequencer shared round-robin between requesters.
// Sequence lasts ROC_CYCLES+1 cycles (SEQ + DONE); requests wait until IDLE, held level until ack.
`timescale 1ns/1ps
module pu_msp430_glbl_ctrl
    import pu_msp430_glbl_pkg::*;
#(
    parameter int ROC_CYCLES = 16,
    parameter int TOC_CYCLES = 4,
    parameter int NREQ       = 3
) (
    input  logic            mclk,
    input  logic            reset_n,
    input  logic [NREQ-1:0] req_i,
    output logic [NREQ-1:0] ack_o,
    output logic [NREQ-1:0] grant_o,
    output logic            gsr_o,
    output logic            prld_o,
    output logic            gts_o,
    output logic            busy_o
);

    localparam int CW = cnt_width(ROC_CYCLES);
    localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam logic [CW-1:0] ROC_L  = CW'(ROC_CYCLES);
    localparam logic [CW-1:0] TOC_L  = CW'(TOC_CYCLES);
    localparam logic [CW-1:0] LAST_L = CW'(ROC_CYCLES - 1);

    if (ROC_CYCLES < 1 || ROC_CYCLES > 65535) begin : g_bad_roc
        $error("ROC_CYCLES out of range 1..65535");
    end
    if (TOC_CYCLES < 0 || TOC_CYCLES > ROC_CYCLES) begin : g_bad_toc
        $error("TOC_CYCLES out of range 0..ROC_CYCLES");
    end
    if (NREQ < 1 || NREQ > NREQ_MAX) begin : g_bad_nreq
        $error("NREQ out of range 1..NREQ_MAX");
    end

    glbl_state_e     state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic            por_q, por_d;
    logic [NREQ-1:0] grant_q, grant_d;
    logic [NREQ-1:0] ack_q, ack_d;
    logic [PW-1:0]   ptr_q, ptr_d;

    logic [NREQ-1:0] arb_gnt;
    logic [PW-1:0]   arb_idx;
    logic            arb_any;

    pu_msp430_glbl_rr_arb #(
        .NREQ (NREQ),
        .PW   (PW)
    ) u_arb (
        .req_i (req_i),
        .ptr_i (ptr_q),
        .gnt_o (arb_gnt),
        .idx_o (arb_idx),
        .any_o (arb_any)
    );

    // Reset lands directly in SEQ so the power-on sequence needs no trigger.
    always_ff @(posedge mclk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= SEQ;
            cnt_q   <= '0;
            por_q   <= 1'b1;
            grant_q <= '0;
            ack_q   <= '0;
            ptr_q   <= PW'(NREQ - 1);
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            por_q   <= por_d;
            grant_q <= grant_d;
            ack_q   <= ack_d;
            ptr_q   <= ptr_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        por_d   = por_q;
        grant_d = grant_q;
        ptr_d   = ptr_q;
        ack_d   = '0;
        case (state_q)
            IDLE: begin
                if (arb_any) begin
                    state_d = SEQ;
                    cnt_d   = '0;
                    grant_d = arb_gnt;
                    ptr_d   = arb_idx;
                end
            end
            SEQ: begin
                cnt_d = cnt_q + CW'(1);
                // Ack is registered on entry to DONE so it is visible during DONE.
                if (cnt_q == LAST_L) begin
                    state_d = DONE;
                    if (!por_q) ack_d = grant_q;
                end
            end
            DONE: begin
                state_d = IDLE;
                por_d   = 1'b0;
                grant_d = '0;
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        gsr_o   = (state_q == SEQ) && (cnt_q < ROC_L);
        prld_o  = gsr_o;
        gts_o   = (state_q == SEQ) && (cnt_q < TOC_L);
        busy_o  = (state_q == SEQ) || (state_q == DONE);
        grant_o = grant_q;
        ack_o   = ack_q;
    end

endmodule
